// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: Tuse/Tnew data hazards, MDU busy sequencing.
// Optional stall statistics counter enabled by defining HAZARD_STALL_STATS_EN.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_md,
    input  logic [4:0]  e_waddr,
    input  logic        e_regwrite,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_waddr,
    input  logic        m_regwrite,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        stall,
    output logic        flush_de,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // A source register is stale if a pending writer produces it later than D needs it.
    function automatic logic src_hazard(
        input logic       use_src,
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] ew,
        input logic       ewe,
        input logic [1:0] etn,
        input logic [4:0] mw,
        input logic       mwe,
        input logic [1:0] mtn
    );
        logic from_e;
        logic from_m;
        from_e = ewe && (ew == src) && (etn > tuse);
        from_m = mwe && (mw == src) && (mtn > tuse);
        return use_src && (src != 5'd0) && (from_e || from_m);
    endfunction

    md_state_t        state_r;
    md_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             hz_rs_s;
    logic             hz_rt_s;
    logic             hz_md_s;
    logic             stall_s;

    // Combinational hazard detection; stall and flush share one zero-latency source.
    always_comb begin
        hz_rs_s = src_hazard(d_use_rs, d_rs, d_tuse_rs, e_waddr, e_regwrite, e_tnew,
                             m_waddr, m_regwrite, m_tnew);
        hz_rt_s = src_hazard(d_use_rt, d_rt, d_tuse_rt, e_waddr, e_regwrite, e_tnew,
                             m_waddr, m_regwrite, m_tnew);
        hz_md_s = d_md && (e_md_start || (state_r == BUSY));
        stall_s = hz_rs_s || hz_rt_s || hz_md_s;
    end

    assign stall    = stall_s;
    assign flush_de = stall_s;
    assign md_busy  = (state_r == BUSY);

    // MDU sequencer next-state; a start while busy is ignored.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (e_md_start) begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = e_md_div ? DIV_LOAD : MULT_LOAD;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            BUSY: begin
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // MDU sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'h0000_0000;
`endif

endmodule
